// File: rtl/madd_eval_pkg.sv
// Shared types and constants for evaluating the approximate 2x2 multiply-add circuit.
package madd_eval_pkg;

  localparam int unsigned N_VEC   = 64;
  localparam int unsigned VEC_W   = 6;
  localparam int unsigned OUT_W   = 4;
  localparam int unsigned ERR_W   = 4;
  localparam int unsigned SUM_W   = 10;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned DIFF_W  = 5;

  localparam int unsigned FIELD_W = 2;
  localparam int unsigned A_LSB   = 0;
  localparam int unsigned B_LSB   = 2;
  localparam int unsigned C_LSB   = 4;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VEC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // |x - y| with one guard bit so the signed difference cannot overflow
  function automatic logic [ERR_W-1:0] abs_diff(input logic [OUT_W-1:0] x,
                                                input logic [OUT_W-1:0] y);
    logic signed [DIFF_W-1:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    return d[DIFF_W-1] ? ERR_W'(-d) : ERR_W'(d);
  endfunction

endpackage

// File: rtl/madd_exact_ref.sv
// Golden combinational a*b+c for a 6-bit input vector {c, b, a}.
module madd_exact_ref
  import madd_eval_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [OUT_W-1:0] exact_c
);

  logic [FIELD_W-1:0] a;
  logic [FIELD_W-1:0] b;
  logic [FIELD_W-1:0] c;

  assign a = vec[A_LSB +: FIELD_W];
  assign b = vec[B_LSB +: FIELD_W];
  assign c = vec[C_LSB +: FIELD_W];

  assign exact_c = OUT_W'(a) * OUT_W'(b) + OUT_W'(c);

endmodule

// File: rtl/madd_err_monitor.sv
// Exhaustive error sweep of an approximate multiply-add: drives all 64 vectors,
// compares each response against the exact model and accumulates error statistics.
module madd_err_monitor
  import madd_eval_pkg::*;
#(
  parameter int unsigned ET     = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] approx_in,
  input  logic [OUT_W-1:0] approx_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] max_err,
  output logic [SUM_W-1:0] err_sum,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [VEC_W-1:0] first_viol_vec,
  output logic             first_viol_valid
);

  localparam int unsigned         SETTLE_W    = 4;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  state_e              state_q;
  state_e              state_d;
  logic [SETTLE_W-1:0] settle_q;
  logic [VEC_W-1:0]    vec_q;

  logic [OUT_W-1:0]    exact_c;
  logic [ERR_W-1:0]    err_c;
  logic                viol_c;
  logic                start_ok_c;
  logic [SUM_W:0]      sum_ext_c;
  logic [SUM_W-1:0]    sum_sat_c;
  logic                busy_c;
  logic                done_c;
  logic                pass_c;

  madd_exact_ref u_exact_ref (
    .vec     (vec_q),
    .exact_c (exact_c)
  );

  assign approx_in  = vec_q;
  assign err_c      = abs_diff(exact_c, approx_out);
  assign viol_c     = 32'(err_c) > ET;
  assign start_ok_c = start && ((state_q == IDLE) || (state_q == DONE));
  assign sum_ext_c  = (SUM_W+1)'(err_sum) + (SUM_W+1)'(err_c);
  assign sum_sat_c  = sum_ext_c[SUM_W] ? '1 : sum_ext_c[SUM_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start)                  state_d = APPLY;
      APPLY:      if (settle_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:     state_d = (vec_q == LAST_VEC) ? DONE : APPLY;
      default:    state_d = IDLE;
    endcase
  end

  // Status decode, registered below so done trails the DONE state by one cycle
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    pass_c = 1'b0;
    unique case (state_q)
      APPLY, SAMPLE: busy_c = 1'b1;
      DONE: begin
        done_c = 1'b1;
        pass_c = (viol_cnt == '0);
      end
      default: ;
    endcase
  end

  // Vector sequencing and error accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q         <= '0;
      vec_q            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      max_err          <= '0;
      err_sum          <= '0;
      viol_cnt         <= '0;
      first_viol_vec   <= '0;
      first_viol_valid <= 1'b0;
    end else begin
      busy <= busy_c;
      done <= done_c;
      pass <= pass_c;
      if (start_ok_c) begin
        settle_q         <= '0;
        vec_q            <= '0;
        max_err          <= '0;
        err_sum          <= '0;
        viol_cnt         <= '0;
        first_viol_vec   <= '0;
        first_viol_valid <= 1'b0;
      end else if (state_q == APPLY) begin
        settle_q <= (settle_q == SETTLE_LAST) ? '0 : settle_q + SETTLE_W'(1);
      end else if (state_q == SAMPLE) begin
        settle_q <= '0;
        if (err_c > max_err) max_err <= err_c;
        err_sum <= sum_sat_c;
        if (viol_c && (viol_cnt != '1)) viol_cnt <= viol_cnt + CNT_W'(1);
        if (viol_c && !first_viol_valid) begin
          first_viol_vec   <= vec_q;
          first_viol_valid <= 1'b1;
        end
        if (vec_q != LAST_VEC) vec_q <= vec_q + VEC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_madd_err_monitor.sv
// Scoreboard bench for madd_err_monitor: sweeps are queued with hand-computed
// results and a per-DUT monitor checks them when done rises.
module tb_madd_err_monitor;

  typedef struct {
    int max_err;
    int err_sum;
    int viol_cnt;
    int first_vec;
    int first_valid;
    int pass;
    int latency;
    int start_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  int         mode1 = 0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  logic [5:0] approx_in1, approx_in3, fvec1, fvec3;
  logic [3:0] approx_out1, approx_out3, ref_out1, ref_out3, max_err1, max_err3;
  logic [9:0] err_sum1, err_sum3;
  logic [6:0] viol_cnt1, viol_cnt3;
  logic       busy1, done1, pass1, fval1, busy3, done3, pass3, fval3;
  logic       done1_prev = 1'b0;
  logic       done3_prev = 1'b0;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  // All-vector expectations: exact sums 240 over 64 vectors, 6 vectors exceed 8,
  // 53 vectors have exact < 7 (error vs 15 above 8).
  localparam exp_t E_EXACT = '{0, 0, 0, 0, 0, 1, 129, 0};
  localparam exp_t E_ZERO  = '{12, 240, 6, 15, 1, 0, 129, 0};
  localparam exp_t E_FULL  = '{15, 720, 53, 0, 1, 0, 129, 0};
  localparam exp_t E_S3    = '{0, 0, 0, 0, 0, 1, 257, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  madd_exact_ref u_ref1 (.vec(approx_in1), .exact_c(ref_out1));
  madd_exact_ref u_ref3 (.vec(approx_in3), .exact_c(ref_out3));

  always_comb begin
    approx_out1 = ref_out1;
    if (mode1 == 1)      approx_out1 = 4'd0;
    else if (mode1 == 2) approx_out1 = 4'd15;
  end
  assign approx_out3 = ref_out3;

  madd_err_monitor #(.ET(8), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .approx_in(approx_in1), .approx_out(approx_out1),
    .busy(busy1), .done(done1), .pass(pass1),
    .max_err(max_err1), .err_sum(err_sum1), .viol_cnt(viol_cnt1),
    .first_viol_vec(fvec1), .first_viol_valid(fval1)
  );

  madd_err_monitor #(.ET(8), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .approx_in(approx_in3), .approx_out(approx_out3),
    .busy(busy3), .done(done3), .pass(pass3),
    .max_err(max_err3), .err_sum(err_sum3), .viol_cnt(viol_cnt3),
    .first_viol_vec(fvec3), .first_viol_valid(fval3)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic score(input string tag, input exp_t e, input int me, input int es,
                       input int vc, input int fv, input int fvl, input int ps,
                       input int now);
    check({tag, "_latency"},     now - e.start_cyc, e.latency);
    check({tag, "_max_err"},     me,  e.max_err);
    check({tag, "_err_sum"},     es,  e.err_sum);
    check({tag, "_viol_cnt"},    vc,  e.viol_cnt);
    check({tag, "_first_valid"}, fvl, e.first_valid);
    check({tag, "_pass"},        ps,  e.pass);
    if (e.first_valid != 0) check({tag, "_first_vec"}, fv, e.first_vec);
  endtask

  // Monitors: pop and compare on each rising edge of done
  always @(posedge clk) begin
    #1;
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
      else begin
        e1 = q1.pop_front();
        score("dut1", e1, int'(max_err1), int'(err_sum1), int'(viol_cnt1),
              int'(fvec1), int'(fval1), int'(pass1), cyc);
      end
    end
    done1_prev = done1;
  end

  always @(posedge clk) begin
    #1;
    if (done3 && !done3_prev) begin
      if (q3.size() == 0) check("dut3_unexpected_done", 1, 0);
      else begin
        e3 = q3.pop_front();
        score("dut3", e3, int'(max_err3), int'(err_sum3), int'(viol_cnt3),
              int'(fvec3), int'(fval3), int'(pass3), cyc);
      end
    end
    done3_prev = done3;
  end

  task automatic run_sweep(input int id, input int mode, input exp_t e_in,
                           input bit pulse20, input bit chk_clear);
    exp_t e;
    bit   seen;
    e = e_in;
    @(negedge clk);
    if (id == 1) begin
      mode1  = mode;
      start1 = 1'b1;
    end else begin
      start3 = 1'b1;
    end
    @(posedge clk);
    #1;
    e.start_cyc = cyc;
    if (id == 1) q1.push_back(e);
    else         q3.push_back(e);
    if (chk_clear) begin
      check("restart_max_err",  int'(max_err1),  0);
      check("restart_err_sum",  int'(err_sum1),  0);
      check("restart_viol_cnt", int'(viol_cnt1), 0);
      check("restart_fvalid",   int'(fval1),     0);
    end
    seen = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      start1 = (id == 1) && pulse20 && (k == 20);
      start3 = 1'b0;
      @(posedge clk);
      #1;
      if (id == 1 && k == 5) begin
        check("approx_in_at_5", int'(approx_in1), 2);
        check("busy_at_5",      int'(busy1),      1);
      end
      if ((id == 1) ? done1 : done3) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", int'(seen), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_approx_in", int'(approx_in1), 0);
    check("rst_busy",      int'(busy1),      0);
    check("rst_done",      int'(done1),      0);
    check("rst_pass",      int'(pass1),      0);
    check("rst_max_err",   int'(max_err1),   0);
    check("rst_err_sum",   int'(err_sum1),   0);
    check("rst_viol_cnt",  int'(viol_cnt1),  0);
    check("rst_fvalid",    int'(fval1),      0);
    check("rst_done3",     int'(done3),      0);
    @(negedge clk);
    rst = 1'b0;

    run_sweep(1, 0, E_EXACT, 1'b1, 1'b0);
    run_sweep(1, 1, E_ZERO,  1'b0, 1'b0);
    run_sweep(1, 2, E_FULL,  1'b0, 1'b0);
    run_sweep(1, 0, E_EXACT, 1'b0, 1'b1);

    // Reset in the middle of a stuck-at-15 sweep
    @(negedge clk);
    mode1  = 2;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (48) @(negedge clk);
    check("midsweep_busy", int'(busy1), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_approx_in", int'(approx_in1), 0);
    check("midrst_busy",      int'(busy1),      0);
    check("midrst_done",      int'(done1),      0);
    check("midrst_pass",      int'(pass1),      0);
    check("midrst_max_err",   int'(max_err1),   0);
    check("midrst_err_sum",   int'(err_sum1),   0);
    check("midrst_viol_cnt",  int'(viol_cnt1),  0);
    check("midrst_fvec",      int'(fvec1),      0);
    check("midrst_fvalid",    int'(fval1),      0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_stays_idle", int'(busy1), 0);

    run_sweep(1, 0, E_EXACT, 1'b0, 1'b0);
    run_sweep(3, 0, E_S3,    1'b0, 1'b0);

    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/madd_err_monitor.md
MADD_ERR_MONITOR -- requirements
Module: madd_err_monitor

Interface
REQ-001 SHALL have parameter ET, default 8, meaning the maximum tolerated absolute error per input vector.
REQ-002 SHALL have parameter SETTLE, default 1, range 1..15, meaning the cycles each vector is held before sampling.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: sweep request, sampled in IDLE or DONE.
REQ-006 SHALL have port approx_in, output, 6 bits: vector driven to the approximate circuit (bit k drives in<k>).
REQ-007 SHALL have port approx_out, input, 4 bits: response of the approximate circuit (bit k is out<k>).
REQ-008 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-009 SHALL have port done, output, 1 bit: results valid, held as a level.
REQ-010 SHALL have port pass, output, 1 bit: done and viol_cnt==0.
REQ-011 SHALL have port max_err, output, 4 bits: worst absolute error so far.
REQ-012 SHALL have port err_sum, output, 10 bits: sum of absolute errors, maximum 64*15=960.
REQ-013 SHALL have port viol_cnt, output, 7 bits: number of vectors with error > ET (0..64).
REQ-014 SHALL have port first_viol_vec, output, 6 bits: lowest vector index that violated.
REQ-015 SHALL have port first_viol_valid, output, 1 bit: first_viol_vec is meaningful.

Function
REQ-016 Exact model SHALL be a=vec[1:0], b=vec[3:2], c=vec[5:4], exact=a*b+c, 4 bits unsigned (range 0..12).
REQ-017 Error SHALL be |exact - approx_out| computed on 5-bit signed intermediates, yielding 4 bits.
REQ-018 FSM SHALL use states IDLE, APPLY, SAMPLE, DONE.
REQ-019 IDLE/DONE with start=1 SHALL clear all accumulators and first_viol_valid, set vec=0, and go to APPLY.
REQ-020 APPLY SHALL hold approx_in=vec for exactly SETTLE cycles, then go to SAMPLE.
REQ-021 SAMPLE (one cycle) SHALL compare approx_out and update max_err, err_sum and viol_cnt.
REQ-022 SAMPLE SHALL latch first_viol_vec and set first_viol_valid on the first violation only.
REQ-023 SAMPLE SHALL go to DONE if vec==63; otherwise it SHALL increment vec and return to APPLY.
REQ-024 done SHALL rise 64*(SETTLE+1)+1 cycles after the start-sampling edge (129 for SETTLE=1).
REQ-025 busy SHALL be 1 in APPLY and SAMPLE only; done SHALL be 1 in DONE only.
REQ-026 start while busy SHALL be ignored.
REQ-027 vec SHALL NOT wrap past 63 within a sweep.
REQ-028 Accumulators SHALL saturate at their widths, which is unreachable by construction.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst SHALL override start and may occur in any state, including mid-sweep.
REQ-031 On the cycle after rst, state SHALL be IDLE.
REQ-032 On the cycle after rst, approx_in, busy, done, pass, max_err, err_sum, viol_cnt, first_viol_vec and first_viol_valid SHALL all be 0.

Structure
REQ-033 Package madd_eval_pkg SHALL hold the state enum, N_VEC=64, the output widths and the vector field slicing constants.
REQ-034 Sub-module madd_exact_ref (combinational a*b+c) SHALL be instantiated once so it can be reused by other checkers.

Verification
REQ-035 approx_out driven by a second madd_exact_ref instance, SETTLE=1 -> done at cycle 129, max_err=0, err_sum=0, viol_cnt=0, pass=1, first_viol_valid=0.
REQ-036 approx_out stuck at 0 -> max_err=12, err_sum=240, viol_cnt=6, first_viol_vec=15, pass=0.
REQ-037 approx_out stuck at 15 -> max_err=15, err_sum=720, first_viol_vec=0, pass=0.
REQ-038 rst asserted at cycle 50 of a sweep -> all outputs 0 and IDLE next cycle; a restart then gives the REQ-035 results.
REQ-039 start pulsed at cycle 20 of a sweep -> ignored, done still at 129.
REQ-040 start in DONE -> accumulators cleared, new sweep begins.
REQ-041 SETTLE=3 run -> done at cycle 257.
